// File: rtl/instr_fetcher.sv
// Z80 instruction fetcher: pulls opcode bytes one at a time, consults an external
// length/group decoder after each byte, and reports the completed instruction.
module instr_fetcher #(
    parameter logic [7:0] GROUP_NEED_MORE_BYTES = 8'hFF,
    parameter logic [7:0] GROUP_ILLEGAL_INSTR   = 8'hFE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] pc,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_data,
    output logic [31:0] instr,
    output logic [1:0]  op_len,
    input  logic [2:0]  dec_len,
    input  logic [7:0]  dec_group,
    output logic        valid,
    output logic [2:0]  insn_len,
    output logic [7:0]  insn_group,
    output logic        illegal,
    output logic [15:0] next_pc,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] base_q, base_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] instr_q, instr_d;
    logic [2:0]  len_q, len_d;
    logic [7:0]  group_q, group_d;
    logic        illegal_q, illegal_d;
    logic [15:0] next_pc_q, next_pc_d;
    logic [15:0] cur_addr;

    // Byte address wraps naturally in 16 bits, so FFFF is followed by 0000.
    assign cur_addr = base_q + {13'd0, count_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            base_q    <= 16'd0;
            count_q   <= 3'd0;
            instr_q   <= 32'd0;
            len_q     <= 3'd0;
            group_q   <= 8'd0;
            illegal_q <= 1'b0;
            next_pc_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            count_q   <= count_d;
            instr_q   <= instr_d;
            len_q     <= len_d;
            group_q   <= group_d;
            illegal_q <= illegal_d;
            next_pc_q <= next_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        count_d   = count_q;
        instr_d   = instr_q;
        len_d     = len_q;
        group_d   = group_q;
        illegal_d = illegal_q;
        next_pc_d = next_pc_q;
        mem_rd    = 1'b0;
        valid     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = pc;
                    count_d = 3'd0;
                    instr_d = 32'd0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    instr_d[{count_q[1:0], 3'b000} +: 8] = mem_data;
                    count_d = count_q + 3'd1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // A full four-byte buffer always completes, using whatever group the decoder shows.
                if ((count_q < 3'd4) &&
                    ((dec_group == GROUP_NEED_MORE_BYTES) || (count_q < dec_len))) begin
                    state_d = FETCH;
                end else begin
                    len_d     = count_q;
                    group_d   = dec_group;
                    illegal_d = (dec_group == GROUP_ILLEGAL_INSTR);
                    next_pc_d = cur_addr;
                    state_d   = DONE;
                end
            end
            DONE: begin
                valid   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr   = (state_q == FETCH) ? cur_addr : 16'd0;
    assign busy       = (state_q != IDLE);
    assign op_len     = count_q[2] ? 2'd3 : count_q[1:0];
    assign instr      = instr_q;
    assign insn_len   = len_q;
    assign insn_group = group_q;
    assign illegal    = illegal_q;
    assign next_pc    = next_pc_q;

endmodule

// File: doc/instr_fetcher.md
INSTR_FETCHER -- requirements
Module: instr_fetcher

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports are listed below, clock and reset first.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 start  in  1  begin fetching an instruction at pc; sampled only in IDLE.
REQ-005 pc  in  16  address of the first opcode byte; latched on accepted start.
REQ-006 mem_rd  out  1  byte read request.
REQ-007 mem_addr  out  16  byte address of the current read.
REQ-008 mem_ready  in  1  mem_data valid this cycle; completes the read.
REQ-009 mem_data  in  8  read byte.
REQ-010 instr  out  32  accumulated bytes; byte k at bits [8k+7:8k]; unfetched bytes 0.
REQ-011 op_len  out  2  bytes held, clipped: 0..3 (4 bytes -> 3); drives decoder.
REQ-012 dec_len  in  3  decoder length for current instr/op_len.
REQ-013 dec_group  in  8  decoder group (z80.vh INSN_GROUP_* codes).
REQ-014 valid  out  1  one-cycle pulse: instruction complete.
REQ-015 insn_len  out  3  final instruction length 1..4.
REQ-016 insn_group  out  8  final group code.
REQ-017 illegal  out  1  final group is INSN_GROUP_ILLEGAL_INSTR.
REQ-018 next_pc  out  16  latched pc + insn_len, mod 2^16.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 SHALL implement states IDLE, FETCH, CHECK, DONE.
REQ-021 IDLE: on start=1 latch base=pc, clear instr, count=0 -> FETCH. start is ignored in every other state.
REQ-022 FETCH: mem_rd=1, mem_addr=base+count mod 2^16 (FFFF wraps to 0000); both stay stable until mem_ready=1.
REQ-023 FETCH with mem_ready=1: store mem_data into byte[count], count+1 -> CHECK. mem_rd=0 outside FETCH.
REQ-024 CHECK: if count<4 and (dec_group==INSN_GROUP_NEED_MORE_BYTES or count<dec_len) -> FETCH; else -> DONE.
REQ-025 On CHECK->DONE: latch insn_len=count, insn_group=dec_group, illegal, next_pc=base+count.
REQ-026 Forced completion at count==4 SHALL use the decoder group then presented.
REQ-027 DONE: valid=1 for exactly one cycle -> IDLE.
REQ-028 insn_len, insn_group, illegal, next_pc, instr SHALL hold from DONE until the next accepted start.
REQ-029 Latency, zero-wait memory: valid in cycle 2n+1 after the start-sampling edge, n = byte count. Each wait cycle adds 1.
REQ-030 count is a 3-bit internal counter; op_len=count[1:0] for count<=3, 3 for count==4.
REQ-031 mem_ready outside FETCH SHALL be ignored.

Reset
REQ-032 Reset SHALL force IDLE immediately, regardless of clk.
REQ-033 Reset SHALL clear all outputs to 0: mem_rd, mem_addr, instr, op_len, valid, insn_len, insn_group, illegal, next_pc, busy.
REQ-034 Reset mid-operation SHALL abort the fetch with no valid pulse. The first start after reset release SHALL work normally.

Verification
REQ-035 NOP: byte 00 at pc=0100, zero-wait -> one read at 0100; valid in cycle 3; insn_len=1, group=NOP, next_pc=0101, instr=00000000.
REQ-036 LD BC,nn: bytes 01 34 12 at 2000 -> reads 2000,2001,2002; valid in cycle 7; instr=00123401, insn_len=3, next_pc=2003.
REQ-037 LD IX,nn across wrap: bytes DD 21 34 12 at FFFE -> reads FFFE,FFFF,0000,0001; instr=123421DD; insn_len=4; next_pc=0002.
REQ-038 Illegal: bytes ED 00 at 3000 -> 2 reads; illegal=1, group=ILLEGAL_INSTR, insn_len=2, next_pc=3002; one-cycle valid.
REQ-039 Wait states: mem_ready low 3 cycles on byte 2 of 01 34 12 -> mem_addr=2001 and mem_rd stay stable; valid in cycle 10.
REQ-040 Reset in FETCH of byte 2 -> mem_rd and busy drop immediately; no valid; next start at 0100 with 00 completes as in REQ-035.
